// File: rtl/dm_slave.sv
// Data-memory slave for a CPU load/store port: fixed-latency request/acknowledge
// handshake, little-endian byte/halfword/word access with alignment checking.
module dm_slave #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_t;

    typedef struct packed {
        logic          we;
        logic [AW+1:0] addr;
        logic [1:0]    size;
        logic          sign_ext;
        logic [31:0]   wdata;
    } req_t;

    localparam state_t ACC_STATE = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;

    state_t        state, state_nx;
    logic [3:0]    cnt;
    req_t          in_req, req_q, cur;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          accept, enter_resp, bad;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wword, rword, load_val;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          unused_addr;

    // Upper address bits are deliberately ignored so accesses wrap around the array.
    assign unused_addr = ^addr[31:AW+2];

    always_comb begin
        in_req = '{we: we, addr: addr[AW+1:0], size: size, sign_ext: sign_ext, wdata: wdata};
    end

    assign accept     = req && (state != S_WAIT);
    // With zero wait cycles the access completes on the acceptance edge, so it must
    // operate on the live request rather than the latched copy.
    assign cur        = (WAIT_CYCLES == 0) ? in_req : req_q;
    assign enter_resp = (state == S_WAIT && cnt == 4'd0) || (accept && WAIT_CYCLES == 0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every combinational output gets a default first; otherwise an unassigned
    // path would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = ACC_STATE;
            S_WAIT:  if (cnt == 4'd0) state_nx = S_RESP;
            S_RESP:  state_nx = req ? ACC_STATE : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ack   = 1'b0;
        busy  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        case (state)
            S_WAIT: busy = 1'b1;
            S_RESP: begin
                ack   = 1'b1;
                rdata = rdata_q;
                err   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 4'd0;
            req_q <= '0;
        end else if (accept) begin
            cnt   <= CNT_INIT;
            req_q <= in_req;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Lane selection, alignment check and write-data replication for the current access.
    always_comb begin
        idx      = cur.addr[AW+1:2];
        rword    = mem[idx];
        bad      = 1'b0;
        be       = 4'b0000;
        wword    = cur.wdata;
        load_val = rword;
        lane_b   = rword[8*cur.addr[1:0] +: 8];
        lane_h   = cur.addr[1] ? rword[31:16] : rword[15:0];
        case (cur.size)
            SZ_BYTE: begin
                be       = 4'b0001 << cur.addr[1:0];
                wword    = {4{cur.wdata[7:0]}};
                load_val = {{24{cur.sign_ext & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                bad      = cur.addr[0];
                be       = cur.addr[1] ? 4'b1100 : 4'b0011;
                wword    = {2{cur.wdata[15:0]}};
                load_val = {{16{cur.sign_ext & lane_h[15]}}, lane_h};
            end
            SZ_WORD: begin
                bad = (cur.addr[1:0] != 2'b00);
                be  = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
        if (bad || !cur.we) be = 4'b0000;
    end

    // NOTE: the array is cleared on reset because the interface guarantees zeroed
    // memory after reset; this rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (enter_resp) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= bad;
            rdata_q <= (bad || cur.we) ? '0 : load_val;
        end
    end

endmodule

// File: tb/tb_dm_slave.sv
// Scoreboard bench for dm_slave: each accepted request queues its expected response,
// and a negedge monitor checks every ack for data, error flag and latency.
module tb_dm_slave;

    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 1024;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, sign_ext;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        ack, err, busy;
    logic [31:0] rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    dm_slave #(.WAIT_CYCLES(WAIT_CYCLES), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
        .sign_ext(sign_ext), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: pops one expectation per ack; outside ack outputs must be zero.
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            check("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rdata", rdata, e.rdata);
                check("err", 32'(err), 32'(e.err));
                check("latency", 32'(cyc - e.cyc + 1), 32'(WAIT_CYCLES + 1));
            end
        end else begin
            check("idle_rdata", rdata, 32'd0);
            check("idle_err", 32'(err), 32'd0);
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] wd);
        req = 1'b1; we = w; addr = a; size = sz; sign_ext = sx; wdata = wd;
    endtask

    task automatic expect_resp(input logic [31:0] rd, input logic e_err);
        exp_t e;
        e.rdata = rd;
        e.err   = e_err;
        e.cyc   = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check("ack_received", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Called just after a negedge; the request is accepted at the next rising edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd,
                        input logic [31:0] rd, input logic e_err);
        drive(w, a, sz, sx, wd);
        @(posedge clk);
        #1;
        expect_resp(rd, e_err);
        req = 1'b0;
        check("busy_in_wait", 32'(busy), 32'd1);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; sign_ext = 1'b0; wdata = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);

        // Release and request on the same step: acceptance at the very first edge.
        @(negedge clk);
        reset = 1'b1;
        send(1'b1, 32'h10, SZ_W, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
        send(1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h1234_5678, 1'b0);

        // Byte store/load with both extensions.
        send(1'b1, 32'h11, SZ_B, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
        send(1'b0, 32'h11, SZ_B, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0);
        send(1'b0, 32'h11, SZ_B, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
        send(1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h1234_8078, 1'b0);

        // Misaligned and illegal accesses: err, zero data, memory untouched.
        send(1'b0, 32'h13, SZ_H, 1'b1, 32'h0, 32'h0, 1'b1);
        send(1'b1, 32'h12, SZ_W, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b1, 32'h10, SZ_X, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b1, 32'h11, SZ_H, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h1234_8078, 1'b0);

        // Halfword lanes and right-aligned store data with junk upper bits.
        send(1'b1, 32'h22, SZ_H, 1'b0, 32'hAAAA_BEEF, 32'h0, 1'b0);
        send(1'b0, 32'h22, SZ_H, 1'b1, 32'h0, 32'hFFFF_BEEF, 1'b0);
        send(1'b0, 32'h22, SZ_H, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0);
        send(1'b1, 32'h23, SZ_B, 1'b0, 32'hFFFF_FF12, 32'h0, 1'b0);
        send(1'b0, 32'h20, SZ_W, 1'b1, 32'h0, 32'h12EF_0000, 1'b0);
        send(1'b0, 32'h12, SZ_H, 1'b1, 32'h0, 32'h0000_1234, 1'b0);

        // A request pulse during WAIT must be ignored entirely.
        drive(1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        expect_resp(32'h1234_8078, 1'b0);
        drive(1'b1, 32'h10, SZ_W, 1'b0, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        send(1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h1234_8078, 1'b0);

        // req held high: fields changed during WAIT, second request accepted from RESP.
        drive(1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        expect_resp(32'h1234_8078, 1'b0);
        drive(1'b0, 32'h10, SZ_B, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        expect_resp(32'h0000_0078, 1'b0);
        req = 1'b0;
        wait_drain();

        // Reset during WAIT abandons the store and clears the array.
        drive(1'b1, 32'h20, SZ_W, 1'b0, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("busy_before_abort", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send(1'b0, 32'h20, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0);
        send(1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0);

        // Address wrap-around beyond DEPTH_WORDS.
        send(1'b1, 32'h1000, SZ_W, 1'b0, 32'h0000_00AA, 32'h0, 1'b0);
        send(1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'h0000_00AA, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_slave.md
DM_SLAVE -- requirements
Module: dm_slave

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait cycles between request acceptance and acknowledge (legal range 0-15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-low (reset=0 asserts).
REQ-005 SHALL have port req, input, 1, meaning a request valid from the CPU initiator.
REQ-006 SHALL have port we, input, 1, meaning 1=store and 0=load.
REQ-007 SHALL have port addr, input, 32, meaning the byte address.
REQ-008 SHALL have port size, input, 2, meaning 00=byte, 01=halfword, 10=word, 11=illegal.
REQ-009 SHALL have port sign_ext, input, 1, meaning load data is sign-extended (1) or zero-extended (0).
REQ-010 SHALL have port wdata, input, 32, meaning store data, right-aligned for byte/halfword.
REQ-011 SHALL have port ack, output, 1, meaning a one-cycle response pulse.
REQ-012 SHALL have port rdata, output, 32, meaning load result, valid while ack=1.
REQ-013 SHALL have port err, output, 1, meaning the request was rejected, valid while ack=1.
REQ-014 SHALL have port busy, output, 1, high in the WAIT state.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; ack=1 only in RESP.
REQ-016 SHALL accept a request at a rising edge when req=1 and state is IDLE or RESP; accepted we/addr/size/sign_ext/wdata SHALL be latched at that edge.
REQ-017 SHALL ignore req while in WAIT; latched fields SHALL not change.
REQ-018 On acceptance with WAIT_CYCLES>0, SHALL enter WAIT with counter=WAIT_CYCLES-1, decrement each cycle, and enter RESP at the edge the counter is 0.
REQ-019 On acceptance with WAIT_CYCLES=0, SHALL enter RESP directly; ack is therefore high in the cycle after acceptance.
REQ-020 ack SHALL be high for exactly WAIT_CYCLES+1 cycles after the acceptance edge, lasting one cycle.
REQ-021 From RESP, SHALL return to IDLE unless a new request is accepted at that edge (back-to-back).
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-023 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or size=11 SHALL produce err=1, rdata=0, no memory change, and the same latency.
REQ-024 A store SHALL update memory at the edge entering RESP, little-endian: byte lane addr[1:0], halfword lanes {addr[1],0}; other lanes unchanged.
REQ-025 A load SHALL register rdata at the edge entering RESP from the selected lanes, extended to 32 bits per sign_ext; word loads ignore sign_ext.
REQ-026 Store responses SHALL drive rdata=0.
REQ-027 Outside RESP, rdata and err SHALL be 0.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, counter 0, ack=0, err=0, busy=0, rdata=0, and all memory words to 0.
REQ-029 reset asserted mid-request SHALL abandon it: no ack and no memory write SHALL follow.
REQ-030 The first acceptance SHALL be possible at the first rising edge after reset returns to 1.

Verification
REQ-031 Store word 0x12345678 to 0x10, load word 0x10 -> ack exactly 3 cycles after each acceptance, rdata=0x12345678, err=0.
REQ-032 Store byte 0x80 to 0x11, load byte 0x11 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080; load word 0x10 -> 0x12348078.
REQ-033 Load halfword at 0x13 -> ack with err=1, rdata=0; subsequent load word 0x10 unchanged.
REQ-034 Pulse req during WAIT -> ignored, one ack only; req held high through RESP -> next request accepted back-to-back, second ack 3 cycles later.
REQ-035 Store word to 0x20, assert reset during WAIT -> no ack; after release, load 0x20 -> rdata=0.
REQ-036 DEPTH_WORDS=1024: store 0xAA to 0x1000, load word 0x0 -> 0x000000AA (wrap).
